dev_bus_ctrl: RTL and testbench

DEV_BUS_CTRL -- requirements
Module: dev_bus_ctrl

---
 rtl/dev_bus_ctrl_pkg.sv | 22 ++
 rtl/dev_bus_ctrl_if.sv | 32 +++
 rtl/dev_bus_decode.sv | 18 +
 rtl/dev_bus_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dev_bus_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/dev_bus_ctrl_pkg.sv
// Shared definitions for the device bus controller: state encodings and generic
// control/status pin positions within each device's ctrl/stat word.
package dev_bus_ctrl_pkg;

   localparam logic [1:0] DB_STATE_IDLE     = 2'd0;
   localparam logic [1:0] DB_STATE_PRE      = 2'd1;
   localparam logic [1:0] DB_STATE_WAIT_ACK = 2'd2;
   localparam logic [1:0] DB_STATE_RESP     = 2'd3;

   typedef enum logic [1:0] {
      StIdle    = DB_STATE_IDLE,
      StPre     = DB_STATE_PRE,
      StWaitAck = DB_STATE_WAIT_ACK,
      StResp    = DB_STATE_RESP
   } db_state_e;

   // Bit positions inside a device's ctrl word (WRITE/READ) and stat word (ACK).
   localparam int unsigned WRITE_PIN = 0;
   localparam int unsigned READ_PIN  = 1;
   localparam int unsigned ACK_PIN   = 0;

endpackage

// File: rtl/dev_bus_ctrl_if.sv
// CPU request/response channel plus the shared device bus, bundled for dev_bus_ctrl.
// The master modport is the controller's view; slave is the CPU/device side.
interface dev_bus_ctrl_if #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned NUM_DEV    = 2
);

   logic                          req_valid;
   logic                          req_ready;
   logic                          req_write;
   logic [WORD_WIDTH-1:0]         req_addr;
   logic [WORD_WIDTH-1:0]         req_wdata;
   logic                          rsp_valid;
   logic [WORD_WIDTH-1:0]         rsp_rdata;
   logic                          rsp_err;
   logic [NUM_DEV*WORD_WIDTH-1:0] dev_ctrl;
   logic [NUM_DEV*WORD_WIDTH-1:0] dev_stat;
   logic [WORD_WIDTH-1:0]         addr;
   logic [WORD_WIDTH-1:0]         data_out;
   logic [WORD_WIDTH-1:0]         data_in;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, dev_stat, data_in,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, dev_ctrl, addr, data_out
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, dev_stat, data_in,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, dev_ctrl, addr, data_out
   );

endinterface

// File: rtl/dev_bus_decode.sv
// Splits a request address into device index (top SEL_BITS) and in-device offset,
// and flags whether the index names an attached device.
module dev_bus_decode #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned NUM_DEV    = 2,
   parameter int unsigned SEL_BITS   = 4
) (
   input  logic [WORD_WIDTH-1:0] addr_i,
   output logic [SEL_BITS-1:0]   dev_idx_o,
   output logic [WORD_WIDTH-1:0] offset_o,
   output logic                  in_range_o
);

   assign dev_idx_o  = addr_i[WORD_WIDTH-1 -: SEL_BITS];
   assign offset_o   = {{SEL_BITS{1'b0}}, addr_i[WORD_WIDTH-SEL_BITS-1:0]};
   assign in_range_o = 32'(dev_idx_o) < NUM_DEV;

endmodule

// File: rtl/dev_bus_ctrl.sv
// Four-phase pin-handshake controller bridging CPU requests onto NUM_DEV devices.
// Optional ACK-wait timeout is enabled by defining DEV_BUS_TIMEOUT_EN.
module dev_bus_ctrl #(
   parameter int unsigned WORD_WIDTH     = 32,
   parameter int unsigned NUM_DEV        = 2,
   parameter int unsigned SEL_BITS       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic           clk,
   input  logic           rst,
   dev_bus_ctrl_if.master bus
);

   import dev_bus_ctrl_pkg::*;

   db_state_e             state_q, state_d;
   logic [SEL_BITS-1:0]   idx_q, idx_d;
   logic                  write_q, write_d;
   logic [WORD_WIDTH-1:0] addr_q, addr_d;
   logic [WORD_WIDTH-1:0] dout_q, dout_d;
   logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [SEL_BITS-1:0]   dec_idx;
   logic [WORD_WIDTH-1:0] dec_offset;
   logic                  dec_in_range;
   logic [SEL_BITS-1:0]   ack_idx;
   logic                  ack;
   logic                  cnt_clr;
   logic                  timeout;
   logic [NUM_DEV*WORD_WIDTH-1:0] dev_ctrl;
   logic                  unused_stat;

   dev_bus_decode #(
      .WORD_WIDTH(WORD_WIDTH),
      .NUM_DEV   (NUM_DEV),
      .SEL_BITS  (SEL_BITS)
   ) u_decode (
      .addr_i    (bus.req_addr),
      .dev_idx_o (dec_idx),
      .offset_o  (dec_offset),
      .in_range_o(dec_in_range)
   );

   // Only the ACK bit of each status word is consumed.
   assign unused_stat = ^bus.dev_stat;

   // In IDLE the ACK of the device being requested decides PRE vs WAIT_ACK.
   assign ack_idx = (state_q == StIdle) ? dec_idx : idx_q;

   always_comb begin
      ack = 1'b0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (ack_idx == SEL_BITS'(i)) begin
            ack = bus.dev_stat[i*WORD_WIDTH + ACK_PIN];
         end
      end
   end

`ifdef DEV_BUS_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (state_q == StPre || state_q == StWaitAck) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      write_d = write_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               idx_d   = dec_idx;
               write_d = bus.req_write;
               addr_d  = dec_offset;
               dout_d  = bus.req_write ? bus.req_wdata : '0;
               cnt_clr = 1'b1;
               if (!dec_in_range) begin
                  state_d = StResp;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else if (ack) begin
                  state_d = StPre;
               end else begin
                  state_d = StWaitAck;
               end
            end
         end
         StPre: begin
            if (!ack) begin
               state_d = StWaitAck;
               cnt_clr = 1'b1;
            end else if (timeout) begin
               state_d = StResp;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         StWaitAck: begin
            // A real ACK wins over a timeout landing on the same edge.
            if (ack) begin
               state_d = StResp;
               rdata_d = write_q ? '0 : bus.data_in;
               err_d   = 1'b0;
            end else if (timeout) begin
               state_d = StResp;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      dev_ctrl = '0;
      if (state_q == StWaitAck) begin
         for (int i = 0; i < NUM_DEV; i++) begin
            if (idx_q == SEL_BITS'(i)) begin
               dev_ctrl[i*WORD_WIDTH + WRITE_PIN] = write_q;
               dev_ctrl[i*WORD_WIDTH + READ_PIN]  = ~write_q;
            end
         end
      end
   end

   assign bus.dev_ctrl  = dev_ctrl;
   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_err   = err_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.addr      = addr_q;
   assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_dev_bus_ctrl.sv
// Directed bench for dev_bus_ctrl: per-transaction timeline model checked every cycle,
// plus literal spot checks. Defining DEV_BUS_TIMEOUT_EN switches on the timeout case.
module tb_dev_bus_ctrl;

   localparam int W  = 32;
   localparam int ND = 2;
   localparam int SB = 4;
   localparam int TO = 8;
`ifdef DEV_BUS_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   dev_bus_ctrl_if #(.WORD_WIDTH(W), .NUM_DEV(ND)) bus ();

   dev_bus_ctrl #(
      .WORD_WIDTH    (W),
      .NUM_DEV       (ND),
      .SEL_BITS      (SB),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Expected outputs for the current cycle.
   logic          m_ready, m_rsp, m_err;
   logic [31:0]   m_rdata, m_addr, m_dout;
   logic [63:0]   m_ctrl;
   bit            chk_en = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   int rsp_cnt = 0;
   int pin1w_cnt = 0;
   int pin0r_cnt = 0;
   int ctrl_any_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 64'(bus.req_ready), 64'(m_ready));
         check("rsp_valid", 64'(bus.rsp_valid), 64'(m_rsp));
         check("rsp_err",   64'(bus.rsp_err),   64'(m_err));
         check("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rdata));
         check("addr",      64'(bus.addr),      64'(m_addr));
         check("data_out",  64'(bus.data_out),  64'(m_dout));
         check("dev_ctrl",  bus.dev_ctrl,       m_ctrl);
         if (bus.rsp_valid === 1'b1) rsp_cnt++;
         if (bus.dev_ctrl[W] === 1'b1) pin1w_cnt++;
         if (bus.dev_ctrl[1] === 1'b1) pin0r_cnt++;
         if (|bus.dev_ctrl) ctrl_any_cnt++;
      end
   end

   task automatic model_reset();
      m_ready = 1'b1;
      m_rsp   = 1'b0;
      m_err   = 1'b0;
      m_rdata = '0;
      m_addr  = '0;
      m_dout  = '0;
      m_ctrl  = '0;
   endtask

   task automatic ack_set(input int k, input logic v);
      bus.dev_stat[k*W] = v;
   endtask

   // p: sampling edges (from accept) the selected ACK is still high; d: cycles the
   // device lets the pin sit before ACKing; abort_at: cycle at which rst is pulsed.
   task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input int p, input int d, input logic [31:0] rd,
                          input logic noise, input int abort_at);
      int sel, win, last;
      bit oor, tmo;
      logic [63:0] pin;
      sel  = int'(a[31:28]);
      oor  = sel >= ND;
      tmo  = !oor && TimeoutEn && d > TO;
      win  = tmo ? TO : d;
      last = oor ? 1 : p + win + 1;
      pin  = oor ? 64'd0 : (64'd1 << (sel*W + (wr ? 0 : 1)));
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = wd;
      for (int k = 0; k < ND; k++) ack_set(k, (k == sel) ? (p > 0) : noise);
      for (int i = 1; i <= last + 1; i++) begin
         @(posedge clk);
         #1;
         if (abort_at != 0 && i == abort_at + 1) begin
            rst = 1'b0;
            model_reset();
            break;
         end
         if (i == 1) begin
            bus.req_valid = 1'b0;
            m_ready = 1'b0;
            m_addr  = a & 32'h0FFF_FFFF;
            m_dout  = wr ? wd : 32'h0;
         end
         if (!oor && i == p) ack_set(sel, 1'b0);
         if (!oor && !tmo && i == p + d) begin
            ack_set(sel, 1'b1);
            bus.data_in = rd;
         end else begin
            bus.data_in = 32'hDEAD_BEEF;
         end
         m_ctrl = (i >= p + 1 && i <= p + win) ? pin : 64'd0;
         m_rsp  = (i == last);
         if (i == last) begin
            m_err   = oor || tmo;
            m_rdata = (oor || tmo || wr) ? 32'h0 : rd;
         end
         if (i == last + 1) m_ready = 1'b1;
         if (abort_at != 0 && i == abort_at) rst = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int s_rsp, s_pin, s_any;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.data_in   = 32'hDEAD_BEEF;
      // Non-ACK status bits carry junk; only bit 0 of each slice matters.
      bus.dev_stat  = 64'h5A5A_5A5A_A5A5_A5A4;
      model_reset();
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Write dev1 offset 0x10, ACK after 3 pin cycles.
      s_rsp = rsp_cnt; s_pin = pin1w_cnt;
      run_txn(1'b1, 32'h1000_0010, 32'h0000_00AB, 0, 3, 32'h0, 1'b0, 0);
      check("t1_pin_cycles", 64'(pin1w_cnt - s_pin), 64'd3);
      check("t1_rsp_pulses", 64'(rsp_cnt - s_rsp), 64'd1);
      check("t1_addr", 64'(bus.addr), 64'h10);
      check("t1_data_out", 64'(bus.data_out), 64'hAB);
      check("t1_err", 64'(bus.rsp_err), 64'd0);

      // Read dev0 while dev1's ACK is still high (must be ignored).
      run_txn(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 0, 1, 32'h0000_0055, 1'b1, 0);
      check("t2_rdata", 64'(bus.rsp_rdata), 64'h55);
      check("t2_data_out", 64'(bus.data_out), 64'h0);

      // dev0 ACK held over from previous transaction for two more edges.
      s_pin = pin0r_cnt;
      run_txn(1'b0, 32'h0000_0100, 32'h0, 2, 2, 32'h1234_5678, 1'b0, 0);
      check("t3_pin_cycles", 64'(pin0r_cnt - s_pin), 64'd2);

      // Out-of-range device 3: no pin activity, error response.
      s_any = ctrl_any_cnt; s_rsp = rsp_cnt;
      run_txn(1'b1, 32'h3000_0000, 32'h77, 0, 1, 32'h0, 1'b1, 0);
      check("t4_ctrl_activity", 64'(ctrl_any_cnt - s_any), 64'd0);
      check("t4_rsp_pulses", 64'(rsp_cnt - s_rsp), 64'd1);
      check("t4_err", 64'(bus.rsp_err), 64'd1);
      check("t4_rdata", 64'(bus.rsp_rdata), 64'd0);

      run_txn(1'b0, 32'hF000_0000, 32'h0, 0, 1, 32'h0, 1'b0, 0);
      run_txn(1'b1, 32'h1FFF_FFFC, 32'hFFFF_FFFF, 1, 1, 32'h0, 1'b1, 0);
      check("t6_addr", 64'(bus.addr), 64'h0FFF_FFFC);

      // Long wait: completes normally unless the timeout feature is built in.
      s_pin = pin0r_cnt;
      run_txn(1'b0, 32'h0000_0000, 32'h0, 0, 12, 32'h0BAD_CAFE, 1'b0, 0);
      check("t7_pin_cycles", 64'(pin0r_cnt - s_pin), TimeoutEn ? 64'd8 : 64'd12);
      check("t7_err", 64'(bus.rsp_err), TimeoutEn ? 64'd1 : 64'd0);

      // Reset in the middle of WAIT_ACK.
      s_rsp = rsp_cnt;
      run_txn(1'b1, 32'h1000_0020, 32'h0000_1111, 0, 5, 32'h0, 1'b0, 3);
      idle(3);
      check("t8_rsp_pulses", 64'(rsp_cnt - s_rsp), 64'd0);
      check("t8_ready", 64'(bus.req_ready), 64'd1);
      check("t8_addr", 64'(bus.addr), 64'd0);

      run_txn(1'b0, 32'h1000_0008, 32'h0, 0, 2, 32'hCAFE_F00D, 1'b0, 0);
      check("t9_rdata", 64'(bus.rsp_rdata), 64'hCAFE_F00D);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
